// File: rtl/mul_16bit_wallace_ctrl_pkg.sv
// Shared types and constants for the Wallace multiplier request/response front-end.
package mul_ctrl_pkg;

  localparam int MUL_DATA_WIDTH = 16;
  localparam int RES_WIDTH      = 2 * MUL_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int res_width(input int data_width);
    return 2 * data_width;
  endfunction

endpackage

// File: rtl/mul_16bit_wallace_ctrl_if.sv
// Request, response and multiplier-side signals of the Wallace multiplier front-end.
interface mul_ctrl_if
  import mul_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = MUL_DATA_WIDTH
);

  localparam int RW = res_width(DATA_WIDTH);

  logic                  i_vld;
  logic                  o_rdy;
  logic [DATA_WIDTH-1:0] i_num_x;
  logic [DATA_WIDTH-1:0] i_num_y;

  logic                  o_mul_rst_n;
  logic [DATA_WIDTH-1:0] o_mul_num_x;
  logic [DATA_WIDTH-1:0] o_mul_num_y;
  logic                  i_mul_end;
  logic [RW-1:0]         i_mul_res;
  logic                  i_mul_cry;

  logic                  o_vld;
  logic                  i_rdy;
  logic [RW-1:0]         o_res;
  logic                  o_cry;
  logic                  o_err;

  // Controller side.
  modport slave (
    input  i_vld, i_num_x, i_num_y, i_mul_end, i_mul_res, i_mul_cry, i_rdy,
    output o_rdy, o_mul_rst_n, o_mul_num_x, o_mul_num_y, o_vld, o_res, o_cry, o_err
  );

  // Issuing pipeline plus multiplier side.
  modport master (
    output i_vld, i_num_x, i_num_y, i_mul_end, i_mul_res, i_mul_cry, i_rdy,
    input  o_rdy, o_mul_rst_n, o_mul_num_x, o_mul_num_y, o_vld, o_res, o_cry, o_err
  );

endinterface

// File: rtl/mul_16bit_wallace_ctrl_tmo_cnt.sv
// CALC-phase watchdog counter: clear, enable, terminal count at TIMEOUT-1 (holds there).
module mul_ctrl_tmo_cnt #(
  parameter int TIMEOUT = 32
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_reg <= '0;
    end else if (i_clr) begin
      cnt_reg <= '0;
    end else if (i_en && !o_tc) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign o_tc = (cnt_reg == TC_VAL);

endmodule

// File: rtl/mul_16bit_wallace_ctrl.sv
// Valid/ready front-end that sequences mul_16bit_wallace's restart-by-reset protocol.
// Optional CALC timeout is built when MUL_CTRL_TIMEOUT_EN is defined.
module mul_16bit_wallace_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = MUL_DATA_WIDTH,
  parameter int TIMEOUT    = 32
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  mul_ctrl_if.slave bus
);

  localparam int RW = res_width(DATA_WIDTH);

  state_t                state_reg;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] num_x_reg;
  logic [DATA_WIDTH-1:0] num_y_reg;
  logic [RW-1:0]         res_reg;
  logic                  cry_reg;
  logic                  mul_rst_n_reg;
  logic                  accept;
  logic                  tmo_hit;

  assign accept = (state_reg == IDLE) && bus.i_vld;

`ifdef MUL_CTRL_TIMEOUT_EN
  logic err_reg;

  mul_ctrl_tmo_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (state_reg == LOAD),
    .i_en    ((state_reg == CALC) && !bus.i_mul_end),
    .o_tc    (tmo_hit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_reg <= 1'b0;
    end else if (state_reg == CALC) begin
      // A result arriving on the terminal cycle beats the timeout.
      if (bus.i_mul_end) begin
        err_reg <= 1'b0;
      end else if (tmo_hit) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign bus.o_err = err_reg;
`else
  // No counter: CALC waits for i_mul_end (constant 0 for any legal TIMEOUT >= 2).
  assign tmo_hit   = (TIMEOUT < 2);
  assign bus.o_err = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.i_vld) state_next = LOAD;
      LOAD: state_next = CALC;
      CALC: if (bus.i_mul_end || tmo_hit) state_next = DONE;
      DONE: if (bus.i_rdy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      num_x_reg     <= '0;
      num_y_reg     <= '0;
      res_reg       <= '0;
      cry_reg       <= 1'b0;
      mul_rst_n_reg <= 1'b0;
    end else begin
      // Multiplier runs only while the next state is CALC, so LOAD gives one parked cycle.
      mul_rst_n_reg <= (state_next == CALC);
      if (accept) begin
        num_x_reg <= bus.i_num_x;
        num_y_reg <= bus.i_num_y;
      end
      if (state_reg == CALC) begin
        if (bus.i_mul_end) begin
          res_reg <= bus.i_mul_res;
          cry_reg <= bus.i_mul_cry;
        end else if (tmo_hit) begin
          res_reg <= '0;
          cry_reg <= 1'b0;
        end
      end
    end
  end

  assign bus.o_rdy       = (state_reg == IDLE);
  assign bus.o_vld       = (state_reg == DONE);
  assign bus.o_res       = res_reg;
  assign bus.o_cry       = cry_reg;
  assign bus.o_mul_num_x = num_x_reg;
  assign bus.o_mul_num_y = num_y_reg;
  // System reset parks the multiplier without waiting for a clock edge.
  assign bus.o_mul_rst_n = mul_rst_n_reg & i_rst_n;

endmodule

// File: tb/tb_mul_16bit_wallace_ctrl.sv
// Directed bench for mul_16bit_wallace_ctrl with a latency-programmable signed multiplier stub.
module tb_mul_16bit_wallace_ctrl;
  import mul_ctrl_pkg::*;

  localparam int DW  = 16;
  localparam int RW  = RES_WIDTH;
  localparam int TMO = 32;

  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    int            lat;
    int            bp;
    logic [RW-1:0] res;
    logic          cry;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mul_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  mul_16bit_wallace_ctrl #(
    .DATA_WIDTH (DW),
    .TIMEOUT    (TMO)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Multiplier stub: counts while released, raises end after stub_lat cycles.
  int            stub_lat     = 0;
  logic          stub_ovr     = 1'b0;
  logic          stub_ovr_end = 1'b0;
  logic [7:0]    stub_cnt     = 8'd0;
  logic          stub_end;
  logic [RW-1:0] stub_prod;

  always @(posedge clk) begin
    if (!bus.o_mul_rst_n) stub_cnt <= 8'd0;
    else if (stub_cnt != 8'hFF) stub_cnt <= stub_cnt + 8'd1;
  end

  assign stub_prod = $signed({{16{bus.o_mul_num_x[15]}}, bus.o_mul_num_x}) *
                     $signed({{16{bus.o_mul_num_y[15]}}, bus.o_mul_num_y});
  assign stub_end  = stub_ovr ? stub_ovr_end : (bus.o_mul_rst_n && (int'(stub_cnt) >= stub_lat));
  assign bus.i_mul_end = stub_end;
  assign bus.i_mul_res = stub_ovr ? 32'h1234_5678 : (stub_end ? stub_prod : 32'hDEAD_BEEF);
  assign bus.i_mul_cry = stub_ovr ? 1'b1 : (stub_end & bus.o_mul_num_x[15] & bus.o_mul_num_y[15]);

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the first CALC edge.
  task automatic issue(input logic [DW-1:0] x, input logic [DW-1:0] y);
    bus.i_vld   = 1'b1;
    bus.i_num_x = x;
    bus.i_num_y = y;
    @(negedge clk);
    bus.i_vld = 1'b0;
    chk("load_rdy", bus.o_rdy, 1'b0);
    chk("load_mul_rst_n", bus.o_mul_rst_n, 1'b0);
    chk("load_num_x", bus.o_mul_num_x, x);
    chk("load_num_y", bus.o_mul_num_y, y);
    @(negedge clk);
    chk("calc_mul_rst_n", bus.o_mul_rst_n, 1'b1);
  endtask

  task automatic wait_vld(inout int edges);
    while (!bus.o_vld && edges < 300) begin
      @(negedge clk);
      edges++;
    end
    chk("vld_seen", bus.o_vld, 1'b1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int edges;
    stub_lat  = v.lat;
    bus.i_rdy = (v.bp == 0);
    chk("idle_rdy", bus.o_rdy, 1'b1);
    issue(v.x, v.y);
    edges = 1;
    wait_vld(edges);
    chk("latency", edges, v.lat + 2);
    chk("res", bus.o_res, v.res);
    chk("cry", bus.o_cry, v.cry);
    chk("err", bus.o_err, 1'b0);
    repeat (v.bp) begin
      @(negedge clk);
      chk("hold_vld", bus.o_vld, 1'b1);
      chk("hold_res", bus.o_res, v.res);
      chk("hold_rdy", bus.o_rdy, 1'b0);
    end
    bus.i_rdy = 1'b1;
    @(negedge clk);
    bus.i_rdy = 1'b0;
    chk("consume_rdy", bus.o_rdy, 1'b1);
    chk("consume_vld", bus.o_vld, 1'b0);
    $display("txn %0d: x=%h y=%h lat=%0d bp=%0d -> res=%h cry=%b edges=%0d",
             idx, v.x, v.y, v.lat, v.bp, bus.o_res, bus.o_cry, edges);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int   edges;
    logic saw;

    vecs[0] = '{16'hFFFA, 16'hFFF9, 3, 0, 32'h0000_002A, 1'b1};
    vecs[1] = '{16'hFFFA, 16'h0005, 1, 2, 32'hFFFF_FFE2, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h7FFF, 5, 1, 32'h3FFF_0001, 1'b0};
    vecs[3] = '{16'h8000, 16'h8000, 2, 0, 32'h4000_0000, 1'b1};
    vecs[4] = '{16'h0003, 16'h0004, 0, 3, 32'h0000_000C, 1'b0};
    vecs[5] = '{16'hFFFF, 16'h0001, 1, 0, 32'hFFFF_FFFF, 1'b0};
    vecs[6] = '{16'h0000, 16'h1234, 4, 1, 32'h0000_0000, 1'b0};
    vecs[7] = '{16'h8000, 16'h0001, 7, 0, 32'hFFFF_8000, 1'b0};

    bus.i_vld   = 1'b0;
    bus.i_rdy   = 1'b0;
    bus.i_num_x = '0;
    bus.i_num_y = '0;

    // Reset values
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_rdy", bus.o_rdy, 1'b1);
    chk("rst_vld", bus.o_vld, 1'b0);
    chk("rst_res", bus.o_res, 32'h0);
    chk("rst_cry", bus.o_cry, 1'b0);
    chk("rst_err", bus.o_err, 1'b0);
    chk("rst_mul_rst_n", bus.o_mul_rst_n, 1'b0);
    chk("rst_num_x", bus.o_mul_num_x, 16'h0);
    chk("rst_num_y", bus.o_mul_num_y, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_rdy", bus.o_rdy, 1'b1);
    chk("rel_vld", bus.o_vld, 1'b0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Backpressure with the next request already presented during DONE
    stub_lat  = 1;
    bus.i_rdy = 1'b0;
    issue(16'hFFFA, 16'h0005);
    edges = 1;
    wait_vld(edges);
    chk("bp_res", bus.o_res, 32'hFFFF_FFE2);
    bus.i_vld   = 1'b1;
    bus.i_num_x = 16'h0003;
    bus.i_num_y = 16'h0007;
    stub_lat    = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_vld", bus.o_vld, 1'b1);
      chk("bp_hold_res", bus.o_res, 32'hFFFF_FFE2);
      chk("bp_hold_rdy", bus.o_rdy, 1'b0);
      chk("bp_hold_num_x", bus.o_mul_num_x, 16'hFFFA);
    end
    bus.i_rdy = 1'b1;
    @(negedge clk);
    bus.i_rdy = 1'b0;
    chk("bp_consume_rdy", bus.o_rdy, 1'b1);
    chk("bp_no_same_cycle_accept", bus.o_mul_num_x, 16'hFFFA);
    @(negedge clk);
    bus.i_vld = 1'b0;
    chk("bp_next_accept_rdy", bus.o_rdy, 1'b0);
    chk("bp_next_accept_x", bus.o_mul_num_x, 16'h0003);
    bus.i_rdy = 1'b1;
    edges = 0;
    wait_vld(edges);
    chk("bp_second_res", bus.o_res, 32'h0000_0015);
    @(negedge clk);
    bus.i_rdy = 1'b0;
    chk("bp_second_consumed", bus.o_rdy, 1'b1);
    $display("txn bp: ffFA*0005 held 5 cycles, then 0003*0007 res=%h", bus.o_res);

    // Reset three cycles into CALC
    stub_lat  = 20;
    bus.i_rdy = 1'b1;
    issue(16'h0011, 16'h0022);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mul_rst_n", bus.o_mul_rst_n, 1'b0);
    chk("abort_vld", bus.o_vld, 1'b0);
    chk("abort_rdy", bus.o_rdy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_vld) saw = 1'b1;
    end
    chk("abort_no_vld", saw, 1'b0);
    chk("abort_idle_rdy", bus.o_rdy, 1'b1);
    $display("txn abort: reset mid-CALC, response dropped");

    // i_mul_end outside CALC has no effect
    stub_ovr     = 1'b1;
    stub_ovr_end = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_end_vld", bus.o_vld, 1'b0);
    chk("idle_end_res", bus.o_res, 32'h0);
    stub_ovr_end = 1'b0;
    $display("txn idle_end: end ignored in IDLE");

`ifdef MUL_CTRL_TIMEOUT_EN
    bus.i_rdy = 1'b0;
    issue(16'h0101, 16'h0202);
    edges = 0;
    while (!bus.o_vld && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    chk("tmo_edges", edges, TMO);
    chk("tmo_err", bus.o_err, 1'b1);
    chk("tmo_res", bus.o_res, 32'h0);
    chk("tmo_cry", bus.o_cry, 1'b0);
    bus.i_rdy = 1'b1;
    @(negedge clk);
    bus.i_rdy = 1'b0;
    $display("txn tmo: timeout after %0d edges", edges);

    issue(16'h0101, 16'h0202);
    repeat (TMO - 1) @(negedge clk);
    chk("tc_pre_vld", bus.o_vld, 1'b0);
    stub_ovr_end = 1'b1;
    @(negedge clk);
    stub_ovr_end = 1'b0;
    chk("tc_vld", bus.o_vld, 1'b1);
    chk("tc_err", bus.o_err, 1'b0);
    chk("tc_res", bus.o_res, 32'h1234_5678);
    chk("tc_cry", bus.o_cry, 1'b1);
    bus.i_rdy = 1'b1;
    @(negedge clk);
    bus.i_rdy = 1'b0;
    $display("txn tmo_race: end on terminal cycle wins");
`else
    bus.i_rdy = 1'b0;
    issue(16'h0101, 16'h0202);
    repeat (TMO + 8) @(negedge clk);
    chk("wait_no_vld", bus.o_vld, 1'b0);
    stub_ovr_end = 1'b1;
    @(negedge clk);
    stub_ovr_end = 1'b0;
    chk("wait_vld", bus.o_vld, 1'b1);
    chk("wait_err", bus.o_err, 1'b0);
    chk("wait_res", bus.o_res, 32'h1234_5678);
    bus.i_rdy = 1'b1;
    @(negedge clk);
    bus.i_rdy = 1'b0;
    $display("txn long_calc: no timeout, result after %0d CALC cycles", TMO + 9);
`endif
    stub_ovr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_16bit_wallace_ctrl.md
# mul_16bit_wallace_ctrl

Request/response front-end for the 16-bit Wallace tree multiplier. It sits directly upstream of `mul_16bit_wallace`:
- accepts operand pairs over a valid/ready handshake;
- sequences the multiplier's restart-by-reset protocol;
- captures `o_res`/`o_cry` when the multiplier raises `o_end`;
- holds the result on a valid/ready output until consumed.

It turns the multiplier's reset-triggered, free-running behaviour into a transaction interface usable by an issuing pipeline.

## Interface
Parameters:
- `DATA_WIDTH`, 16, operand width; result width is 2*DATA_WIDTH.
- `TIMEOUT`, 32, max CALC cycles before abort; only used when `MUL_CTRL_TIMEOUT_EN` is defined; must be >= 2.

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_vld`  in  1  request valid.
- `o_rdy`  out  1  request ready; high only in IDLE.
- `i_num_x`  in  DATA_WIDTH  operand X.
- `i_num_y`  in  DATA_WIDTH  operand Y.
- `o_mul_rst_n`  out  1  drives multiplier `i_rst_n`.
- `o_mul_num_x`  out  DATA_WIDTH  registered operand X to multiplier.
- `o_mul_num_y`  out  DATA_WIDTH  registered operand Y to multiplier.
- `i_mul_end`  in  1  multiplier `o_end`.
- `i_mul_res`  in  2*DATA_WIDTH  multiplier `o_res`.
- `i_mul_cry`  in  1  multiplier `o_cry`.
- `o_vld`  out  1  response valid; high only in DONE.
- `i_rdy`  in  1  response ready.
- `o_res`  out  2*DATA_WIDTH  captured product.
- `o_cry`  out  1  captured carry.
- `o_err`  out  1  response was produced by timeout.

## Operation
- FSM states IDLE, LOAD, CALC, DONE.
- **IDLE:**
  - `o_rdy`=1; `o_mul_rst_n`=0 (multiplier parked).
  - On `i_vld`&&`o_rdy`: register X/Y into `o_mul_num_x`/`o_mul_num_y` and go to LOAD.
- **LOAD:**
  - `o_rdy`=0; `o_mul_rst_n`=0 for exactly one cycle with the new operands stable.
  - Unconditionally go to CALC.
- **CALC:**
  - `o_mul_rst_n`=1.
  - On `i_mul_end`=1: capture `i_mul_res`→`o_res`, `i_mul_cry`→`o_cry`, clear `o_err`, go to DONE.
- **DONE:**
  - `o_vld`=1; `o_mul_rst_n`=0.
  - `o_res`/`o_cry`/`o_err` stay stable while `i_rdy`=0.
  - On `i_rdy`=1, go to IDLE.
- `i_mul_end` is ignored outside CALC.
- Operand registers change only on request acceptance.
- No request is accepted in the same cycle a response is consumed; the next acceptance is earliest one cycle later.
- The product is passed through bit-exact with no sign handling; arithmetic semantics are those of `mul_16bit_wallace`.

## Timing
- Reset (async assert, sync release) forces:
  - state=IDLE, `o_rdy`=1, `o_vld`=0;
  - `o_res`=0, `o_cry`=0, `o_err`=0;
  - `o_mul_rst_n`=0, `o_mul_num_x`=0, `o_mul_num_y`=0;
  - timeout counter=0.
- Accept at edge E0 → LOAD during E0..E1 → CALC from E1 (`o_mul_rst_n` rises after E1).
- If `i_mul_end` is first sampled high at edge E1+N, `o_vld` rises after that edge. Request-to-response latency is N+1 edges after acceptance.
- Response is consumed at the first edge with `o_vld`&&`i_rdy`; `o_rdy` is high after that edge.
- `i_rst_n` low mid-operation (LOAD/CALC/DONE) aborts immediately:
  - any pending response is dropped;
  - the multiplier is re-parked via `o_mul_rst_n`=0.
- `o_mul_rst_n` is registered (glitch-free) and combined with `i_rst_n` so it goes low asynchronously with system reset.

## Configuration
- **With `MUL_CTRL_TIMEOUT_EN` defined:**
  - A counter clears on entry to CALC and increments each CALC cycle without `i_mul_end`.
  - If the counter reaches TIMEOUT-1 without `i_mul_end`, go to DONE with `o_res`=0, `o_cry`=0, `o_err`=1.
  - If `i_mul_end` and the timeout occur in the same cycle, `i_mul_end` wins (`o_err`=0).
- **Without the macro:**
  - No counter is generated and `o_err` is tied to 0.
  - CALC waits indefinitely for `i_mul_end`.

## Structure
- Package `mul_ctrl_pkg` holds:
  - the state enum type (`IDLE`, `LOAD`, `CALC`, `DONE`);
  - the default DATA_WIDTH constant;
  - a `RES_WIDTH` = 2*DATA_WIDTH localparam helper.
- One sub-module is natural: `mul_ctrl_tmo_cnt` (clear/enable/terminal-count counter), instantiated only under `MUL_CTRL_TIMEOUT_EN`.
- Integration bench instantiates `mul_16bit_wallace` as the downstream stage.

## Test plan
- **Reset values:** hold `i_rst_n`=0 for 1 cycle → all outputs at reset values; release → `o_rdy`=1, `o_vld`=0.
- **Negative × negative:** X=16'hFFFA, Y=16'hFFF9, `i_rdy`=1 → one LOAD cycle with `o_mul_rst_n`=0, then CALC; `o_vld` with `o_res`=32'h0000_002A, `o_err`=0.
- **Backpressure, then negative × positive:**
  - X=16'hFFFA, Y=16'h0005, `i_rdy` held 0 for 5 cycles after `o_vld` → `o_res`=32'hFFFF_FFE2 stable throughout, `o_rdy`=0.
  - Consume → `o_rdy`=1 next cycle.
  - `i_vld` held high across the response cycle → second request is not accepted until the cycle after consumption.
- **Reset mid-CALC:** assert `i_rst_n`=0 three cycles into CALC → `o_mul_rst_n` low immediately, `o_vld` never asserts, FSM in IDLE after release.
- **Timeout (`MUL_CTRL_TIMEOUT_EN`, TIMEOUT=32):** stub with `i_mul_end` stuck 0 → `o_vld`=1, `o_err`=1, `o_res`=0 exactly 32 edges after CALC entry. Variant: `i_mul_end` rises on the terminal cycle → `o_err`=0 with the captured result.
